// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared rule constants and sizing helper for the life cell grid
//
// Purpose : rule masks for common life-like automata plus the popcount width
//           helper used by the cell and the grid statistics block.
// Ports   : none (package).

package life_pkg;

  // Bit k set means "k live neighbours" triggers the rule (Moore, 0..8).
  localparam logic [8:0] CONWAY_BIRTH   = 9'b000001000;
  localparam logic [8:0] CONWAY_SURVIVE = 9'b000001100;
  localparam logic [8:0] HIGHLIFE_BIRTH = 9'b001001000;

  // Width needed to hold a count of 0..n without overflow.
  function automatic int popcount_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/neighbor_popcount.sv
// rtl/neighbor_popcount.sv - binary adder tree counting set bits of a vector
//
// Purpose : combinational population count of N alive bits, built as a
//           balanced pairwise adder tree.
// Ports   :
//   bits   in   N                   alive bits to count
//   count  out  popcount_w(N)       number of set bits (never overflows)

module neighbor_popcount
  import life_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]              bits,
  output logic [popcount_w(N)-1:0]  count
);

  localparam int W      = popcount_w(N);
  localparam int LEVELS = $clog2(N);
  localparam int NP     = 1 << LEVELS;

  // tree[l][i] holds the partial sum of node i at level l; level 0 is the
  // leaf row padded with zeros up to a power of two.
  logic [W-1:0] tree [0:LEVELS][0:NP-1];

  always_comb begin
    for (int l = 0; l <= LEVELS; l++) begin
      for (int i = 0; i < NP; i++) begin
        tree[l][i] = '0;
      end
    end
    for (int i = 0; i < N; i++) begin
      tree[0][i] = W'(bits[i]);
    end
    for (int l = 0; l < LEVELS; l++) begin
      for (int i = 0; i < (NP >> (l + 1)); i++) begin
        tree[l+1][i] = tree[l][2*i] + tree[l][2*i+1];
      end
    end
  end

  assign count = tree[LEVELS][0];

endmodule

// File: rtl/life_cell_gen.sv
// rtl/life_cell_gen.sv - parametrised life-like cellular automaton cell
//
// Purpose : one grid cell with configurable neighbourhood, runtime birth and
//           survive masks, optional Generations decay states and a
//           synchronous load path. Optional alive-age counter is built only
//           when LIFE_CELL_AGE_EN is defined; otherwise age_q is tied to 0.
// Ports   :
//   clk           in   1               system clock
//   rst           in   1               asynchronous active-high reset
//   ena           in   1               generation-step enable
//   load          in   1               synchronous initial-state load
//   state_0       in   1               alive value used on load
//   birth_mask    in   N_NEIGHBORS+1   bit k: dead cell with k neighbours is born
//   survive_mask  in   N_NEIGHBORS+1   bit k: live cell with k neighbours survives
//   neighbors     in   N_NEIGHBORS     alive bits of adjacent cells
//   state_d       out  SW              combinational next state
//   state_q       out  SW              registered cell state
//   alive_q       out  1               registered, high only in state 1
//   age_q         out  AGE_W           consecutive generations alive

module life_cell_gen
  import life_pkg::*;
#(
  parameter int N_NEIGHBORS = 8,
  parameter int N_STATES    = 2,
  parameter int AGE_W       = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 ena,
  input  logic                                 load,
  input  logic                                 state_0,
  input  logic [N_NEIGHBORS:0]                 birth_mask,
  input  logic [N_NEIGHBORS:0]                 survive_mask,
  input  logic [N_NEIGHBORS-1:0]               neighbors,
  output logic [$clog2(N_STATES)-1:0]          state_d,
  output logic [$clog2(N_STATES)-1:0]          state_q,
  output logic                                 alive_q,
  output logic [AGE_W-1:0]                     age_q
);

  localparam int SW = $clog2(N_STATES);
  localparam int CW = popcount_w(N_NEIGHBORS);

  // A dying live cell enters the first decay state, or goes straight to dead
  // in classic two-state life.
  localparam int              DECAY_I     = (N_STATES == 2) ? 0 : 2;
  localparam logic [SW-1:0]   DECAY_ENTRY = SW'(DECAY_I);
  localparam logic [SW-1:0]   ST_ALIVE    = SW'(1);

  if (N_STATES < 2) begin : g_chk_states
    $error("life_cell_gen: N_STATES must be at least 2");
  end
  if (N_NEIGHBORS < 1) begin : g_chk_neigh
    $error("life_cell_gen: N_NEIGHBORS must be at least 1");
  end

  logic [CW-1:0] count;

  neighbor_popcount #(
    .N (N_NEIGHBORS)
  ) u_popcount (
    .bits  (neighbors),
    .count (count)
  );

  always_comb begin
    state_d = '0;
    if (state_q == '0) begin
      state_d = birth_mask[count] ? ST_ALIVE : '0;
    end else if (state_q == ST_ALIVE) begin
      state_d = survive_mask[count] ? ST_ALIVE : DECAY_ENTRY;
    end else if (int'(state_q) < N_STATES - 1) begin
      // Decay states advance unconditionally; neighbours are ignored.
      state_d = state_q + ST_ALIVE;
    end else begin
      // Last decay state and any unreachable encoding fall back to dead.
      state_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= '0;
      alive_q <= 1'b0;
    end else if (load) begin
      state_q <= SW'(state_0);
      alive_q <= state_0;
    end else if (ena) begin
      state_q <= state_d;
      alive_q <= (state_d == ST_ALIVE);
    end
  end

`ifdef LIFE_CELL_AGE_EN
  logic [AGE_W-1:0] age_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age_r <= '0;
    end else if (load) begin
      age_r <= '0;
    end else if (ena) begin
      // Only an unbroken 1->1 step extends the streak; births start at 0.
      if (state_q == ST_ALIVE && state_d == ST_ALIVE) begin
        if (age_r != {AGE_W{1'b1}}) begin
          age_r <= age_r + AGE_W'(1);
        end
      end else begin
        age_r <= '0;
      end
    end
  end

  assign age_q = age_r;
`else
  assign age_q = '0;
`endif

endmodule

// File: tb/tb_life_cell_gen.sv
// tb/tb_life_cell_gen.sv - directed self-checking bench for life_cell_gen

module tb_life_cell_gen;
  import life_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic       load = 1'b0;
  logic       state_0 = 1'b0;
  logic [8:0] birth_mask = CONWAY_BIRTH;
  logic [8:0] survive_mask = CONWAY_SURVIVE;
  logic [7:0] neighbors = 8'h00;

  logic       d2_state_d, d2_state_q, d2_alive_q;
  logic [7:0] d2_age_q;
  logic [1:0] d4_state_d, d4_state_q;
  logic       d4_alive_q;
  logic [1:0] d4_age_q;

  int vec  = 0;
  int errs = 0;

  always #5 clk = ~clk;

  life_cell_gen #(.N_NEIGHBORS(8), .N_STATES(2), .AGE_W(8)) u_d2 (
    .clk(clk), .rst(rst), .ena(ena), .load(load), .state_0(state_0),
    .birth_mask(birth_mask), .survive_mask(survive_mask), .neighbors(neighbors),
    .state_d(d2_state_d), .state_q(d2_state_q), .alive_q(d2_alive_q), .age_q(d2_age_q)
  );

  life_cell_gen #(.N_NEIGHBORS(8), .N_STATES(4), .AGE_W(2)) u_d4 (
    .clk(clk), .rst(rst), .ena(ena), .load(load), .state_0(state_0),
    .birth_mask(birth_mask), .survive_mask(survive_mask), .neighbors(neighbors),
    .state_d(d4_state_d), .state_q(d4_state_q), .alive_q(d4_alive_q), .age_q(d4_age_q)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_load(input logic v);
    load = 1'b1; state_0 = v; ena = 1'b0;
    tick();
    load = 1'b0;
  endtask

  task automatic do_step(input logic [7:0] nb);
    neighbors = nb; ena = 1'b1;
    tick();
    ena = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    vec++; if (d2_state_q !== 1'b0) begin errs++; $display("FAIL reset_d2_state got=%0d exp=0", d2_state_q); end
    vec++; if (d2_alive_q !== 1'b0) begin errs++; $display("FAIL reset_d2_alive got=%0d exp=0", d2_alive_q); end
    vec++; if (d4_state_q !== 2'd0) begin errs++; $display("FAIL reset_d4_state got=%0d exp=0", d4_state_q); end
    vec++; if (d4_age_q !== 2'd0) begin errs++; $display("FAIL reset_d4_age got=%0d exp=0", d4_age_q); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_birth_death();
    birth_mask = CONWAY_BIRTH; survive_mask = CONWAY_SURVIVE;
    do_load(1'b0);
    neighbors = 8'b00000111; #1;
    vec++; if (d2_state_d !== 1'b1) begin errs++; $display("FAIL birth_state_d got=%0d exp=1", d2_state_d); end
    do_step(8'b00000111);
    vec++; if (d2_state_q !== 1'b1) begin errs++; $display("FAIL birth_state_q got=%0d exp=1", d2_state_q); end
    vec++; if (d2_alive_q !== 1'b1) begin errs++; $display("FAIL birth_alive got=%0d exp=1", d2_alive_q); end
    do_step(8'b00000001);
    vec++; if (d2_state_q !== 1'b0) begin errs++; $display("FAIL lonely_death got=%0d exp=0", d2_state_q); end
  endtask

  task automatic test_survival();
    do_load(1'b1);
    for (int i = 0; i < 3; i++) begin
      do_step(8'b00000011);
      vec++; if (d2_state_q !== 1'b1) begin errs++; $display("FAIL survive_step%0d got=%0d exp=1", i, d2_state_q); end
    end
    do_step(8'hFF);
    vec++; if (d2_state_q !== 1'b0) begin errs++; $display("FAIL overcrowd_death got=%0d exp=0", d2_state_q); end
  endtask

  task automatic test_generations();
    do_load(1'b1);
    do_step(8'h00);
    vec++; if (d4_state_q !== 2'd2) begin errs++; $display("FAIL gen_decay2 got=%0d exp=2", d4_state_q); end
    vec++; if (d4_alive_q !== 1'b0) begin errs++; $display("FAIL gen_alive2 got=%0d exp=0", d4_alive_q); end
    neighbors = 8'hFF; #1;
    vec++; if (d4_state_d !== 2'd3) begin errs++; $display("FAIL gen_state_d2 got=%0d exp=3", d4_state_d); end
    do_step(8'hFF);
    vec++; if (d4_state_q !== 2'd3) begin errs++; $display("FAIL gen_decay3 got=%0d exp=3", d4_state_q); end
    vec++; if (d4_alive_q !== 1'b0) begin errs++; $display("FAIL gen_alive3 got=%0d exp=0", d4_alive_q); end
    do_step(8'hFF);
    vec++; if (d4_state_q !== 2'd0) begin errs++; $display("FAIL gen_wrap got=%0d exp=0", d4_state_q); end
  endtask

  task automatic test_masks();
    do_load(1'b0);
    birth_mask = HIGHLIFE_BIRTH;
    do_step(8'h3F);
    vec++; if (d2_state_q !== 1'b1) begin errs++; $display("FAIL highlife_six got=%0d exp=1", d2_state_q); end
    do_load(1'b0);
    birth_mask = 9'b100000000;
    neighbors = 8'hFF; #1;
    vec++; if (d2_state_d !== 1'b1) begin errs++; $display("FAIL count8_state_d got=%0d exp=1", d2_state_d); end
    neighbors = 8'h7F; #1;
    vec++; if (d2_state_d !== 1'b0) begin errs++; $display("FAIL count7_state_d got=%0d exp=0", d2_state_d); end
    birth_mask = CONWAY_BIRTH;
    @(negedge clk);
  endtask

  task automatic test_priority();
    do_load(1'b0);
    neighbors = 8'b00000111; ena = 1'b0;
    tick();
    vec++; if (d2_state_q !== 1'b0) begin errs++; $display("FAIL hold_no_ena got=%0d exp=0", d2_state_q); end
    load = 1'b1; ena = 1'b1; state_0 = 1'b1; neighbors = 8'h00;
    tick();
    load = 1'b0; ena = 1'b0;
    vec++; if (d2_state_q !== 1'b1) begin errs++; $display("FAIL load_wins_d2 got=%0d exp=1", d2_state_q); end
    vec++; if (d4_state_q !== 2'd1) begin errs++; $display("FAIL load_wins_d4 got=%0d exp=1", d4_state_q); end
  endtask

  task automatic test_async_reset();
    do_load(1'b1);
    do_step(8'h00);
    vec++; if (d4_state_q !== 2'd2) begin errs++; $display("FAIL areset_setup got=%0d exp=2", d4_state_q); end
    #2 rst = 1'b1;
    #1;
    vec++; if (d4_state_q !== 2'd0) begin errs++; $display("FAIL areset_state got=%0d exp=0", d4_state_q); end
    vec++; if (d4_alive_q !== 1'b0) begin errs++; $display("FAIL areset_alive got=%0d exp=0", d4_alive_q); end
    #1 rst = 1'b0;
    do_step(8'b00000111);
    vec++; if (d4_state_q !== 2'd1) begin errs++; $display("FAIL areset_restart got=%0d exp=1", d4_state_q); end
  endtask

  task automatic test_age();
    logic [1:0] exp_age [5];
`ifdef LIFE_CELL_AGE_EN
    exp_age = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
`else
    exp_age = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
    do_load(1'b1);
    vec++; if (d4_age_q !== 2'd0) begin errs++; $display("FAIL age_after_load got=%0d exp=0", d4_age_q); end
    for (int i = 0; i < 5; i++) begin
      do_step(8'b00000111);
      vec++; if (d4_age_q !== exp_age[i]) begin errs++; $display("FAIL age_step%0d got=%0d exp=%0d", i, d4_age_q, exp_age[i]); end
    end
    do_step(8'h00);
    vec++; if (d4_age_q !== 2'd0) begin errs++; $display("FAIL age_death got=%0d exp=0", d4_age_q); end
    vec++; if (d4_state_q !== 2'd2) begin errs++; $display("FAIL age_death_state got=%0d exp=2", d4_state_q); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_birth_death();
    test_survival();
    test_generations();
    test_masks();
    test_priority();
    test_async_reset();
    test_age();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
